move_cmd_queue: RTL and testbench
=================================

Name: move_cmd_queue

Overview:
- Sits directly downstream of the four per-button debouncers (up/down/left/right) in the maze solver front end.
- Turns debounced button levels into discrete move commands. Each fresh press gives one command; a held single button gives auto-repeat commands.
- Commands are buffered in a small FIFO and presented to the maze-walk FSM over a valid/ready handshake.

Parameters:
- CNT_W, 24, width of the repeat timer.
- DELAY_CYCLES, 12_000_000, hold time before the first auto-repeat (must be >=2 and < 2**CNT_W).
- PERIOD_CYCLES, 3_000_000, interval between auto-repeats (must be >=2 and < 2**CNT_W).
- DEPTH, 4, FIFO entries; a power of 2, >=2.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- btn  in  4  debounced button levels. Bit 0 is up, bit 1 down, bit 2 left, bit 3 right.
- cmd_valid  out  1  FIFO non-empty; cmd_dir is valid.
- cmd_dir  out  2  direction at the FIFO head: 0 up, 1 down, 2 left, 3 right.
- cmd_ready  in  1  consumer accepts the head entry this cycle.
- overflow  out  1  one-cycle pulse when an event is dropped because the FIFO is full.
- level  out  $clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset values:
  - btn_q=0, state=IDLE, timer=0.
  - FIFO empty: cmd_valid=0, level=0, overflow=0, cmd_dir=0.
- Edge detect:
  - rise = btn & ~btn_q; btn_q <= btn every cycle.
  - A button already high when reset deasserts produces one event. This is intended.
- Event select, combinational:
  - If rise!=0, the event direction is the lowest set index of rise.
  - Extra simultaneous rising edges in the same cycle are discarded.
- Latency: if btn is first high at edge k, the entry is written at edge k+1, and cmd_valid is high after edge k+1. cmd_valid is registered; no combinational path from btn.
- Repeat FSM, with hold_dir latched on entry to DELAY:
  - IDLE:
    - If rise!=0 and btn is one-hot: go to DELAY, timer=0, hold_dir = the event direction.
  - DELAY:
    - rise!=0 takes priority: re-evaluate as in IDLE (go to DELAY if btn is one-hot, else IDLE). The rise event is emitted; timer=0.
    - Else if btn != onehot(hold_dir): go to IDLE, no event.
    - Else if timer==DELAY_CYCLES-1: emit hold_dir, go to REPEAT, timer=0.
    - Else: timer+1.
  - REPEAT:
    - Same rise and release rules as DELAY.
    - timer==PERIOD_CYCLES-1: emit hold_dir, timer=0.
    - Else: timer+1.
  - At most one event per cycle. A rise event and a timer expiry in the same cycle produce only the rise event.
- FIFO:
  - First-word fall-through.
  - push = event; pop = cmd_valid & cmd_ready.
  - Push and pop in the same cycle leave level unchanged and keep order. This is allowed even when full.
  - Push while full with no pop: event dropped and overflow=1 for that cycle. FIFO contents unchanged; FSM continues normally.
  - Pop while empty is ignored; cmd_ready while empty has no effect.
  - Pointers wrap modulo DEPTH. level is the true count 0..DEPTH.
- Reset mid-operation: the FIFO is flushed, the FSM returns to IDLE, and the timer is cleared. This takes effect at the next edge, regardless of cmd_ready.

Decomposition:
- Package maze_pkg:
  - dir_t, 2-bit enum: DIR_UP=0, DIR_DOWN=1, DIR_LEFT=2, DIR_RIGHT=3.
  - Repeat FSM state enum: IDLE, DELAY, REPEAT.
  - Default timing constants DELAY_CYCLES and PERIOD_CYCLES.
- Sub-module cmd_fifo: parameterised synchronous FWFT FIFO, WIDTH=2 and DEPTH, with ports push/din/pop/dout/empty/full/level.
- Edge detect and the repeat FSM stay in move_cmd_queue.

Test Plan (DELAY_CYCLES=8, PERIOD_CYCLES=4, DEPTH=4, cmd_ready=1 unless stated):
- Tap: btn=0001 for 3 cycles, then 0 -> exactly one cmd with dir=0, cmd_valid high for 1 cycle starting 1 cycle after btn rises, no repeats.
- Hold: btn=0100 for 20 cycles -> cmds with dir=2 at the rise, rise+8, rise+12 and rise+16 (4 total). Release -> no further cmds.
- Simultaneous: btn 0000->1010 in one cycle -> one cmd dir=1, no auto-repeat. Then 1010->1000 -> no event.
- Backpressure/overflow: cmd_ready=0, 5 separate taps -> level reaches 4 and the 5th tap gives an overflow pulse. Raising cmd_ready drains dirs in tap order and level returns to 0.
- Full push+pop: with the FIFO full, a tap arrives in the same cycle as cmd_ready=1 -> no overflow, level stays 4, and the new dir appears last.
- Reset mid-hold: btn=0001 held in REPEAT with 2 entries queued; assert reset for 1 cycle -> cmd_valid=0 and level=0 next cycle. One new event follows, because btn_q reset to 0.

Source files
------------

// File: rtl/maze_pkg.sv
// Shared types and default timing for the maze solver front end.
// Directions, repeat FSM states and the one-hot helper used by the command queue.
package maze_pkg;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } rpt_state_t;

  localparam int DELAY_CYCLES  = 12_000_000;
  localparam int PERIOD_CYCLES = 3_000_000;

  function automatic logic [3:0] dir_onehot(input dir_t d);
    return 4'b0001 << d;
  endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Synchronous first-word fall-through FIFO; the head entry is visible on dout
// whenever empty is low. Push alongside pop is accepted even when full.
module cmd_fifo #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW:0]      count_reg;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == (AW+1)'(DEPTH));
  assign level   = count_reg;
  assign do_pop  = pop & ~empty;
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign do_push = push & (~full | do_pop);
  assign dout    = empty ? '0 : mem_reg[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_reg[wr_ptr_reg] <= din;
  end

endmodule

// File: rtl/move_cmd_queue.sv
// Converts debounced button levels into move commands: one per fresh press,
// auto-repeat while a single button is held, buffered for the maze-walk FSM.
module move_cmd_queue #(
  parameter int CNT_W         = 24,
  parameter int DELAY_CYCLES  = maze_pkg::DELAY_CYCLES,
  parameter int PERIOD_CYCLES = maze_pkg::PERIOD_CYCLES,
  parameter int DEPTH         = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [3:0]               btn,
  output logic                     cmd_valid,
  output logic [1:0]               cmd_dir,
  input  logic                     cmd_ready,
  output logic                     overflow,
  output logic [$clog2(DEPTH):0]   level
);

  import maze_pkg::*;

  logic [3:0]       btn_q_reg;
  logic [3:0]       rise;
  logic             btn_one_hot;
  dir_t             ev_dir;
  rpt_state_t       state_reg, state_next;
  logic [CNT_W-1:0] timer_reg, timer_next;
  dir_t             hold_dir_reg, hold_dir_next;
  logic             push;
  dir_t             push_dir;
  logic             pop;
  logic             fifo_empty;
  logic             fifo_full;
  logic             overflow_reg;
  logic [1:0]       fifo_dout;

  assign rise        = btn & ~btn_q_reg;
  assign btn_one_hot = (btn != 4'd0) && ((btn & (btn - 4'd1)) == 4'd0);

  // Lowest set index wins; other simultaneous edges are discarded.
  always_comb begin
    ev_dir = DIR_UP;
    for (int i = 3; i >= 0; i--) begin
      if (rise[i]) ev_dir = dir_t'(i[1:0]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      btn_q_reg    <= 4'd0;
      state_reg    <= IDLE;
      timer_reg    <= '0;
      hold_dir_reg <= DIR_UP;
      overflow_reg <= 1'b0;
    end else begin
      btn_q_reg    <= btn;
      state_reg    <= state_next;
      timer_reg    <= timer_next;
      hold_dir_reg <= hold_dir_next;
      overflow_reg <= push & fifo_full & ~pop;
    end
  end

  // A rising edge always pre-empts release and timer expiry in the same cycle.
  always_comb begin
    state_next    = state_reg;
    timer_next    = timer_reg;
    hold_dir_next = hold_dir_reg;
    push          = 1'b0;
    push_dir      = ev_dir;
    if (rise != 4'd0) begin
      push       = 1'b1;
      timer_next = '0;
      if (btn_one_hot) begin
        state_next    = DELAY;
        hold_dir_next = ev_dir;
      end else begin
        state_next = IDLE;
      end
    end else begin
      case (state_reg)
        DELAY, REPEAT: begin
          if (btn != dir_onehot(hold_dir_reg)) begin
            state_next = IDLE;
            timer_next = '0;
          end else if ((state_reg == DELAY  && timer_reg == CNT_W'(DELAY_CYCLES - 1)) ||
                       (state_reg == REPEAT && timer_reg == CNT_W'(PERIOD_CYCLES - 1))) begin
            push       = 1'b1;
            push_dir   = hold_dir_reg;
            state_next = REPEAT;
            timer_next = '0;
          end else begin
            timer_next = timer_reg + 1'b1;
          end
        end
        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

  assign pop = cmd_valid & cmd_ready;

  cmd_fifo #(
    .WIDTH (2),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .din   (push_dir),
    .pop   (pop),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .full  (fifo_full),
    .level (level)
  );

  assign cmd_valid = ~fifo_empty;
  assign cmd_dir   = fifo_dout;
  assign overflow  = overflow_reg;

endmodule

// File: tb/tb_move_cmd_queue.sv
// Directed bench for move_cmd_queue with short timing (delay 8, period 4, depth 4).
// Table rows are applied for 'rep' cycles each; outputs are checked on the falling edge.
module tb_move_cmd_queue;

  logic       clk;
  logic       reset;
  logic [3:0] btn;
  logic       cmd_valid;
  logic [1:0] cmd_dir;
  logic       cmd_ready;
  logic       overflow;
  logic [2:0] level;

  int checks;
  int failures;

  typedef struct {
    logic       rst;
    logic [3:0] btn;
    logic       rdy;
    int         rep;
    logic       ev;
    logic [1:0] ed;
    int         el;
    logic       eo;
  } vec_t;

  vec_t vecs[$];

  move_cmd_queue #(
    .CNT_W         (24),
    .DELAY_CYCLES  (8),
    .PERIOD_CYCLES (4),
    .DEPTH         (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .btn       (btn),
    .cmd_valid (cmd_valid),
    .cmd_dir   (cmd_dir),
    .cmd_ready (cmd_ready),
    .overflow  (overflow),
    .level     (level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic add(input logic r, input logic [3:0] b, input logic y, input int rep,
                     input logic ev, input logic [1:0] ed, input int el, input logic eo);
    vec_t v;
    v.rst = r; v.btn = b; v.rdy = y; v.rep = rep;
    v.ev = ev; v.ed = ed; v.el = el; v.eo = eo;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Inputs change on the falling edge; one rising edge later they are sampled again.
  task automatic step(input logic r, input logic [3:0] b, input logic y);
    reset     = r;
    btn       = b;
    cmd_ready = y;
    @(negedge clk);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    reset = 1'b1;
    btn = 4'd0;
    cmd_ready = 1'b1;

    //   rst btn      rdy rep  valid dir level ovf
    // reset
    add(1, 4'b0000, 1, 2,  0, 0, 0, 0);
    // tap
    add(0, 4'b0001, 1, 1,  1, 0, 1, 0);
    add(0, 4'b0001, 1, 2,  0, 0, 0, 0);
    add(0, 4'b0000, 1, 2,  0, 0, 0, 0);
    // simultaneous press: one event, no repeat, partial release silent
    add(0, 4'b1010, 1, 1,  1, 1, 1, 0);
    add(0, 4'b1010, 1, 12, 0, 0, 0, 0);
    add(0, 4'b1000, 1, 2,  0, 0, 0, 0);
    add(0, 4'b0000, 1, 1,  0, 0, 0, 0);
    // backpressure: five taps, fifth overflows
    add(0, 4'b0001, 0, 1,  1, 0, 1, 0);
    add(0, 4'b0000, 0, 1,  1, 0, 1, 0);
    add(0, 4'b0010, 0, 1,  1, 0, 2, 0);
    add(0, 4'b0000, 0, 1,  1, 0, 2, 0);
    add(0, 4'b0100, 0, 1,  1, 0, 3, 0);
    add(0, 4'b0000, 0, 1,  1, 0, 3, 0);
    add(0, 4'b1000, 0, 1,  1, 0, 4, 0);
    add(0, 4'b0000, 0, 1,  1, 0, 4, 0);
    add(0, 4'b0001, 0, 1,  1, 0, 4, 1);
    add(0, 4'b0000, 0, 1,  1, 0, 4, 0);
    add(0, 4'b0000, 1, 1,  1, 1, 3, 0);
    add(0, 4'b0000, 1, 1,  1, 2, 2, 0);
    add(0, 4'b0000, 1, 1,  1, 3, 1, 0);
    add(0, 4'b0000, 1, 1,  0, 0, 0, 0);
    // fill with 3,2,1,0 then push+pop while full
    add(0, 4'b1000, 0, 1,  1, 3, 1, 0);
    add(0, 4'b0000, 0, 1,  1, 3, 1, 0);
    add(0, 4'b0100, 0, 1,  1, 3, 2, 0);
    add(0, 4'b0000, 0, 1,  1, 3, 2, 0);
    add(0, 4'b0010, 0, 1,  1, 3, 3, 0);
    add(0, 4'b0000, 0, 1,  1, 3, 3, 0);
    add(0, 4'b0001, 0, 1,  1, 3, 4, 0);
    add(0, 4'b0000, 0, 1,  1, 3, 4, 0);
    add(0, 4'b0010, 1, 1,  1, 2, 4, 0);
    add(0, 4'b0000, 1, 1,  1, 1, 3, 0);
    add(0, 4'b0000, 1, 1,  1, 0, 2, 0);
    add(0, 4'b0000, 1, 1,  1, 1, 1, 0);
    add(0, 4'b0000, 1, 1,  0, 0, 0, 0);
    // reset mid-hold: two entries queued, FSM in REPEAT
    add(0, 4'b0001, 0, 8,  1, 0, 1, 0);
    add(0, 4'b0001, 0, 3,  1, 0, 2, 0);
    add(1, 4'b0001, 0, 1,  0, 0, 0, 0);
    add(0, 4'b0001, 0, 1,  1, 0, 1, 0);
    add(0, 4'b0000, 1, 2,  0, 0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      for (int r = 0; r < vecs[i].rep; r++) begin
        step(vecs[i].rst, vecs[i].btn, vecs[i].rdy);
        $display("vec %0d.%0d rst=%0b btn=%b rdy=%0b -> valid=%0b dir=%0d level=%0d ovf=%0b",
                 i, r, vecs[i].rst, vecs[i].btn, vecs[i].rdy, cmd_valid, cmd_dir, level, overflow);
        chk($sformatf("vec%0d.%0d cmd_valid", i, r), int'(cmd_valid), int'(vecs[i].ev));
        chk($sformatf("vec%0d.%0d cmd_dir", i, r), int'(cmd_dir), int'(vecs[i].ed));
        chk($sformatf("vec%0d.%0d level", i, r), int'(level), vecs[i].el);
        chk($sformatf("vec%0d.%0d overflow", i, r), int'(overflow), int'(vecs[i].eo));
      end
    end

    // Hold left for 20 cycles: commands at rise, +8, +12, +16, none after release.
    begin
      int ncmd;
      logic exp_v;
      ncmd = 0;
      for (int i = 0; i < 30; i++) begin
        step(1'b0, (i < 20) ? 4'b0100 : 4'b0000, 1'b1);
        exp_v = (i == 0) || (i == 8) || (i == 12) || (i == 16);
        $display("hold %0d valid=%0b dir=%0d level=%0d", i, cmd_valid, cmd_dir, level);
        chk($sformatf("hold%0d cmd_valid", i), int'(cmd_valid), int'(exp_v));
        if (cmd_valid) begin
          ncmd++;
          chk($sformatf("hold%0d cmd_dir", i), int'(cmd_dir), 2);
        end
      end
      chk("hold cmd_count", ncmd, 4);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
